// File: rtl/fifo_ctrl_2k_8.sv
// Single-clock byte FIFO controller around a 2048x8 dual-port RAM with registered read data.
// Optional sticky overflow flag on port ovf when FIFO_OVF_FLAG_EN is defined.
module fifo_ctrl_2k_8 #(
  parameter int ADDR_WIDTH   = 11,
  parameter int DATA_WIDTH   = 8,
  parameter int AFULL_THRESH = 1792
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  almost_full,
`ifdef FIFO_OVF_FLAG_EN
  output logic                  ovf,
`endif
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [DATA_WIDTH-1:0] ram_di,
  output logic [ADDR_WIDTH-1:0] ram_dpra,
  input  logic [DATA_WIDTH-1:0] ram_dpo
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PW-1:0] AFULL = PW'(AFULL_THRESH);

  logic [PW-1:0]         wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]         rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]         mem_cnt, mem_cnt_next;
  logic                  en_reg;
  logic                  out_valid_reg, out_valid_next;
  logic [DATA_WIDTH-1:0] out_data_reg, out_data_next;
  logic                  skid_valid_reg, skid_valid_next;
  logic [DATA_WIDTH-1:0] skid_data_reg, skid_data_next;
  logic                  inflight_reg, inflight_next;
  logic [PW:0]           count_reg, count_next;
  logic                  almost_full_reg, almost_full_next;
  logic                  full, empty, in_fire, out_fire, issue, head_free;
  logic [1:0]            stage_occ;

  // Pointers carry a wrap bit, so the difference spans 0..DEPTH.
  assign mem_cnt = wr_ptr_reg - rd_ptr_reg;
  assign full    = (mem_cnt == DEPTH);
  assign empty   = (mem_cnt == '0);

  assign in_ready  = en_reg & ~full & ~clear;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid_reg & out_ready;
  assign head_free = ~out_valid_reg | out_fire;

  // Output stage slots that will be taken after this edge; head + skid can hold two bytes.
  assign stage_occ = {1'b0, out_valid_reg} + {1'b0, skid_valid_reg}
                   + {1'b0, inflight_reg} - {1'b0, out_fire};
  assign issue     = ~empty & (stage_occ < 2'd2) & ~clear;

  assign ram_we   = in_fire;
  assign ram_a    = wr_ptr_reg[ADDR_WIDTH-1:0];
  assign ram_di   = in_data;
  assign ram_dpra = rd_ptr_reg[ADDR_WIDTH-1:0];

  assign wr_ptr_next  = wr_ptr_reg + {{ADDR_WIDTH{1'b0}}, in_fire};
  assign rd_ptr_next  = rd_ptr_reg + {{ADDR_WIDTH{1'b0}}, issue};
  assign mem_cnt_next = wr_ptr_next - rd_ptr_next;

  always_comb begin
    out_valid_next  = out_valid_reg;
    out_data_next   = out_data_reg;
    skid_valid_next = skid_valid_reg;
    skid_data_next  = skid_data_reg;
    inflight_next   = issue;
    if (head_free) begin
      if (skid_valid_reg) begin
        out_valid_next  = 1'b1;
        out_data_next   = skid_data_reg;
        skid_valid_next = inflight_reg;
        if (inflight_reg) skid_data_next = ram_dpo;
      end else if (inflight_reg) begin
        out_valid_next = 1'b1;
        out_data_next  = ram_dpo;
      end else begin
        out_valid_next = 1'b0;
      end
    end else if (inflight_reg) begin
      skid_valid_next = 1'b1;
      skid_data_next  = ram_dpo;
    end
  end

  assign count_next = {1'b0, mem_cnt_next} + {{PW{1'b0}}, out_valid_next}
                    + {{PW{1'b0}}, skid_valid_next} + {{PW{1'b0}}, inflight_next};
  assign almost_full_next = (mem_cnt_next >= AFULL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_reg          <= 1'b0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      out_valid_reg   <= 1'b0;
      out_data_reg    <= '0;
      skid_valid_reg  <= 1'b0;
      skid_data_reg   <= '0;
      inflight_reg    <= 1'b0;
      count_reg       <= '0;
      almost_full_reg <= 1'b0;
    end else if (clear) begin
      // Flush drops any byte still on ram_dpo by clearing inflight.
      en_reg          <= 1'b1;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      out_valid_reg   <= 1'b0;
      out_data_reg    <= '0;
      skid_valid_reg  <= 1'b0;
      skid_data_reg   <= '0;
      inflight_reg    <= 1'b0;
      count_reg       <= '0;
      almost_full_reg <= 1'b0;
    end else begin
      en_reg          <= 1'b1;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      out_valid_reg   <= out_valid_next;
      out_data_reg    <= out_data_next;
      skid_valid_reg  <= skid_valid_next;
      skid_data_reg   <= skid_data_next;
      inflight_reg    <= inflight_next;
      count_reg       <= count_next;
      almost_full_reg <= almost_full_next;
    end
  end

  assign out_valid   = out_valid_reg;
  assign out_data    = out_data_reg;
  assign count       = count_reg;
  assign almost_full = almost_full_reg;

`ifdef FIFO_OVF_FLAG_EN
  logic ovf_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_reg <= 1'b0;
    end else if (clear) begin
      ovf_reg <= 1'b0;
    end else if (en_reg & in_valid & ~in_ready) begin
      ovf_reg <= 1'b1;
    end
  end

  assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_fifo_ctrl_2k_8.sv
// Directed self-checking bench for fifo_ctrl_2k_8 with a behavioural 2048x8 registered-read RAM.
module tb_fifo_ctrl_2k_8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic [12:0] count;
  logic        almost_full;
`ifdef FIFO_OVF_FLAG_EN
  logic        ovf;
`endif
  logic        ram_we;
  logic [10:0] ram_a;
  logic [7:0]  ram_di;
  logic [10:0] ram_dpra;
  logic [7:0]  ram_dpo;

  logic [7:0]  ram_mem [0:2047];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_a] <= ram_di;
    ram_dpo <= ram_mem[ram_dpra];
  end

  fifo_ctrl_2k_8 dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .count       (count),
    .almost_full (almost_full),
`ifdef FIFO_OVF_FLAG_EN
    .ovf         (ovf),
`endif
    .ram_we      (ram_we),
    .ram_a       (ram_a),
    .ram_di      (ram_di),
    .ram_dpra    (ram_dpra),
    .ram_dpo     (ram_dpo)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int wi;
    int rx;
    logic stalled;
    logic [7:0] held;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_rdy", in_ready, 0);
    check("rst_cnt", count, 0);
    check("rst_ov", {out_valid, out_data}, 0);
    check("rst_af", almost_full, 0);
    reset = 1'b1;
    step();
    #1;
    check("rel_rdy", in_ready, 1);
    $display("txn reset: released");

    // Single byte 0x41, cycle N .. N+4
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h41;
    #1;
    check("one_we", {ram_we, ram_a, ram_di}, {1'b1, 11'd0, 8'h41});
    step();
    in_valid = 1'b0;
    #1;
    check("one_n1", out_valid, 0);
    step();
    #1;
    check("one_n2", out_valid, 0);
    step();
    #1;
    check("one_n3", {out_valid, out_data}, {1'b1, 8'h41});
    check("one_cnt", count, 1);
    step();
    #1;
    check("one_n4", out_valid, 0);
    check("one_cnt0", count, 0);
    $display("txn single: wrote 41, read %0h", 8'h41);

    // Back-to-back stream 0x00..0xFF
    for (int i = 0; i < 259; i++) begin
      in_valid = (i < 256);
      in_data = 8'(i);
      #1;
      if (i < 256) check("strm_rdy", in_ready, 1);
      if (i >= 3) check("strm_out", {out_valid, out_data}, {1'b1, 8'(i - 3)});
      step();
    end
    in_valid = 1'b0;
    #1;
    check("strm_end", {out_valid, count}, 0);
    $display("txn stream: 256 bytes");

    // Fill to full with output stalled; write pointer starts at 257 and wraps
    out_ready = 1'b0;
    for (int n = 0; n < 2050; n++) begin
      in_valid = 1'b1;
      in_data = 8'(n);
      #1;
      check("fill_wr", {in_ready, ram_we, ram_a}, {2'b11, 11'((257 + n) % 2048)});
      if (n == 1000) check("fill_cnt", count, 1000);
      if (n == 1793) check("af_below", almost_full, 0);
      if (n == 1794) check("af_at", almost_full, 1);
      step();
    end
    in_data = 8'h55;
    #1;
    check("full_rdy_we", {in_ready, ram_we}, 0);
    check("full_cnt", count, 2050);
    check("full_af", almost_full, 1);
    check("full_head", {out_valid, out_data}, {1'b1, 8'h00});
    step();
    in_valid = 1'b0;
    #1;
    check("full_stable", {out_valid, out_data}, {1'b1, 8'h00});
`ifdef FIFO_OVF_FLAG_EN
    check("ovf_set", ovf, 1);
`endif
    $display("txn fill: 2050 bytes, push 55 while full");

    out_ready = 1'b1;
    for (int j = 0; j < 2050; j++) begin
      #1;
      check("drain", {out_valid, out_data}, {1'b1, 8'(j)});
      step();
    end
    #1;
    check("drain_end", {out_valid, count, almost_full}, 0);
`ifdef FIFO_OVF_FLAG_EN
    check("ovf_sticky", ovf, 1);
`endif
    $display("txn drain: 2050 bytes");

    // Toggling out_ready under full-rate writes
    wi = 0;
    rx = 0;
    stalled = 1'b0;
    held = 8'h00;
    for (int c = 0; c < 400 && rx < 64; c++) begin
      out_ready = ((c % 2) == 0);
      in_valid = (wi < 64);
      in_data = 8'(8'h80 + wi);
      #1;
      if (stalled) check("tog_hold", {out_valid, out_data}, {1'b1, held});
      if (in_valid && in_ready) wi++;
      if (out_valid && out_ready) begin
        check("tog_data", out_data, 8'(8'h80 + rx));
        rx++;
      end
      stalled = out_valid && !out_ready;
      held = out_data;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("tog_rx", rx, 64);
    check("tog_end", {out_valid, count}, 0);
    $display("txn toggle: 64 bytes");

    // Clear with a read in flight
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_data = 8'(8'h10 + i);
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    #1;
    check("clr_pre_cnt", count, 12);
    out_ready = 1'b1;
    check("clr_pre_hd", out_data, 8'h10);
    step();
    out_ready = 1'b0;
    #1;
    check("clr_infl", {count, out_data}, {13'd11, 8'h11});
    clear = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hEE;
    #1;
    check("clr_we", ram_we, 0);
    step();
    clear = 1'b0;
    in_valid = 1'b0;
    #1;
    check("clr_post", {count, out_valid, in_ready}, {13'd0, 1'b0, 1'b1});
`ifdef FIFO_OVF_FLAG_EN
    check("clr_ovf", ovf, 0);
`endif
    for (int k = 0; k < 3; k++) begin
      step();
      #1;
      check("clr_nostale", {out_valid, count}, 0);
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h99;
    #1;
    check("clr_wr0", {ram_we, ram_a}, {1'b1, 11'd0});
    step();
    in_valid = 1'b0;
    step();
    step();
    #1;
    check("clr_rd", {out_valid, out_data}, {1'b1, 8'h99});
    $display("txn clear: flushed, then wrote 99");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
